// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared bus: grant, track one transaction, turn around.
// Parks the bus while idle and times out silent masters and slaves.
module bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int GNT_TIMEOUT = 4,
  parameter int RSP_TIMEOUT = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic [1:0]                     bus_control,
  output logic [NUM_MASTERS-1:0]         gnt,
  output logic [$clog2(NUM_MASTERS)-1:0] owner,
  output logic                           busy,
  output logic                           bus_oe,
  output logic [NUM_MASTERS-1:0]         bus_err
);

  localparam int OW   = $clog2(NUM_MASTERS);
  localparam int MAXT = (GNT_TIMEOUT > RSP_TIMEOUT) ?
                        GNT_TIMEOUT : RSP_TIMEOUT;
  localparam int CW   = $clog2(MAXT + 1);

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    GRANT    = 4'b0010,
    WAIT_RSP = 4'b0100,
    TURN     = 4'b1000
  } state_t;

  state_t          state;
  logic [OW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic [OW-1:0]   pick;
  logic            found;
  logic            strobe;
  logic            rnw;
  int              j;

  assign strobe  = bus_control[0];
  assign rnw     = bus_control[1];
  assign busy    = (state != IDLE);
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  // Scan backwards so the lowest offset from ptr+1 is the one kept.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      j = int'(ptr) + k + 1;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      if (req[OW'(j)]) begin
        found = 1'b1;
        pick  = OW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      gnt     <= '0;
      owner   <= '0;
      ptr     <= OW'(NUM_MASTERS - 1);
      cnt     <= '0;
      bus_err <= '0;
      bus_oe  <= 1'b1;
    end else begin
      bus_err <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            state  <= GRANT;
            gnt    <= NUM_MASTERS'(1) << pick;
            owner  <= pick;
            ptr    <= pick;
            cnt    <= '0;
            bus_oe <= 1'b0;
          end
        end
        GRANT: begin
          if (strobe) begin
            cnt <= '0;
            if (rnw) begin
              state <= WAIT_RSP;
            end else begin
              state <= TURN;
              gnt   <= '0;
            end
          end else if (!req[owner]) begin
            state  <= IDLE;
            gnt    <= '0;
            bus_oe <= 1'b1;
          end else if (cnt == CW'(GNT_TIMEOUT - 1)) begin
            state   <= TURN;
            gnt     <= '0;
            bus_err <= gnt;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT_RSP: begin
          // A response on the last counted cycle beats the timeout.
          if (strobe) begin
            state <= TURN;
            gnt   <= '0;
          end else if (cnt == CW'(RSP_TIMEOUT - 1)) begin
            state   <= TURN;
            gnt     <= '0;
            bus_err <= gnt;
          end else begin
            cnt <= cnt_inc;
          end
        end
        TURN: begin
          state  <= IDLE;
          bus_oe <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          gnt    <= '0;
          bus_oe <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: grant order, transaction tracking, timeouts, reset.
// Expected grants go through a queue and are popped when a grant appears.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [3:0] req;
  logic [1:0] bus_control;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       bus_oe;
  logic [3:0] bus_err;

  int vecs = 0;
  int errs = 0;
  int exp_q[$];

  bus_arbiter dut (
    .clk(clk),
    .n_rst(n_rst),
    .req(req),
    .bus_control(bus_control),
    .gnt(gnt),
    .owner(owner),
    .busy(busy),
    .bus_oe(bus_oe),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_gnt(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (gnt != 4'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    req = '0;
    bus_control = '0;
    repeat (2) tick();
    vecs++;
    if ({gnt, bus_err, bus_oe, busy, owner} !== 12'b0000_0000_1_0_00) begin
      errs++;
      $display("FAIL reset: gnt=%b err=%b oe=%b busy=%b own=%0d, want 0 0 1 0 0",
               gnt, bus_err, bus_oe, busy, owner);
    end
    n_rst = 1'b1;
    tick();
    vecs++;
    if (gnt !== 4'b0 || bus_oe !== 1'b1) begin
      errs++;
      $display("FAIL idle_after_reset: gnt=%b oe=%b, want 0000 1", gnt, bus_oe);
    end
  endtask

  task automatic test_single_write();
    int n, e;
    req = 4'b0001;
    exp_q.push_back(0);
    wait_gnt(n);
    e = exp_q.pop_front();
    vecs++;
    if (n != 1 || gnt !== 4'(1 << e) || owner !== 2'(e) ||
        bus_oe !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL write_grant: gnt=%b own=%0d lat=%0d oe=%b, want %b %0d 1 0",
               gnt, owner, n, bus_oe, 4'(1 << e), e);
    end
    tick();
    vecs++;
    if (gnt !== 4'b0001) begin
      errs++;
      $display("FAIL write_hold: gnt=%b, want 0001", gnt);
    end
    bus_control = 2'b01;
    req = 4'b0000;
    tick();
    bus_control = 2'b00;
    vecs++;
    if (gnt !== 4'b0 || busy !== 1'b1 || bus_oe !== 1'b0) begin
      errs++;
      $display("FAIL write_turn: gnt=%b busy=%b oe=%b, want 0000 1 0",
               gnt, busy, bus_oe);
    end
    tick();
    vecs++;
    if (bus_oe !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL write_park: oe=%b busy=%b, want 1 0", bus_oe, busy);
    end
  endtask

  task automatic test_round_robin();
    int n, e, mptr;
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    mptr = 3;
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      mptr = (mptr + 1) % 4;
      exp_q.push_back(mptr);
      wait_gnt(n);
      e = exp_q.pop_front();
      vecs++;
      if (gnt !== 4'(1 << e) || owner !== 2'(e) ||
          n != ((r == 0) ? 1 : 2)) begin
        errs++;
        $display("FAIL rr_grant%0d: gnt=%b own=%0d wait=%0d, want %b %0d %0d",
                 r, gnt, owner, n, 4'(1 << e), e, (r == 0) ? 1 : 2);
      end
      bus_control = 2'b01;
      if (r == 4) req = 4'b0000;
      tick();
      bus_control = 2'b00;
    end
    repeat (2) tick();
  endtask

  task automatic test_read_resp();
    int n, e;
    req = 4'b0100;
    exp_q.push_back(2);
    wait_gnt(n);
    e = exp_q.pop_front();
    vecs++;
    if (gnt !== 4'(1 << e) || owner !== 2'(e)) begin
      errs++;
      $display("FAIL read_grant: gnt=%b own=%0d, want %b %0d",
               gnt, owner, 4'(1 << e), e);
    end
    bus_control = 2'b11;
    req = 4'b0000;
    tick();
    bus_control = 2'b00;
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) tick();
      vecs++;
      if (gnt !== 4'b0100 || bus_err !== 4'b0 || busy !== 1'b1) begin
        errs++;
        $display("FAIL read_wait%0d: gnt=%b err=%b busy=%b, want 0100 0000 1",
                 i, gnt, bus_err, busy);
      end
    end
    bus_control = 2'b01;
    tick();
    bus_control = 2'b00;
    vecs++;
    if (gnt !== 4'b0 || bus_err !== 4'b0 || busy !== 1'b1 || bus_oe !== 1'b0) begin
      errs++;
      $display("FAIL read_turn: gnt=%b err=%b busy=%b oe=%b, want 0000 0000 1 0",
               gnt, bus_err, busy, bus_oe);
    end
    tick();
    vecs++;
    if (bus_oe !== 1'b1 || busy !== 1'b0 || bus_err !== 4'b0) begin
      errs++;
      $display("FAIL read_park: oe=%b busy=%b err=%b, want 1 0 0000",
               bus_oe, busy, bus_err);
    end
  endtask

  task automatic test_rsp_timeout(input bit last_rsp);
    int n, e;
    logic [3:0] want_err;
    want_err = last_rsp ? 4'b0000 : 4'b0100;
    req = 4'b0100;
    exp_q.push_back(2);
    wait_gnt(n);
    e = exp_q.pop_front();
    vecs++;
    if (gnt !== 4'(1 << e)) begin
      errs++;
      $display("FAIL rto_grant: gnt=%b, want %b", gnt, 4'(1 << e));
    end
    bus_control = 2'b11;
    req = 4'b0001;
    for (int i = 1; i <= 16; i++) begin
      tick();
      bus_control = 2'b00;
      vecs++;
      if (bus_err !== 4'b0 || gnt !== 4'b0100) begin
        errs++;
        $display("FAIL rto_wait%0d: err=%b gnt=%b, want 0000 0100",
                 i, bus_err, gnt);
      end
      if (i == 16 && last_rsp) bus_control = 2'b01;
    end
    tick();
    bus_control = 2'b00;
    vecs++;
    if (bus_err !== want_err || gnt !== 4'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL rto_end(last=%0d): err=%b gnt=%b busy=%b, want %b 0000 1",
               last_rsp, bus_err, gnt, busy, want_err);
    end
    tick();
    vecs++;
    if (bus_err !== 4'b0) begin
      errs++;
      $display("FAIL rto_pulse: err=%b, want 0000", bus_err);
    end
    exp_q.push_back(0);
    wait_gnt(n);
    e = exp_q.pop_front();
    vecs++;
    if (gnt !== 4'(1 << e) || owner !== 2'(e) || n != 1) begin
      errs++;
      $display("FAIL rto_next: gnt=%b own=%0d wait=%0d, want %b %0d 1",
               gnt, owner, n, 4'(1 << e), e);
    end
    req = 4'b0000;
    repeat (2) tick();
  endtask

  task automatic test_gnt_timeout();
    int n, e;
    req = 4'b0010;
    exp_q.push_back(1);
    wait_gnt(n);
    e = exp_q.pop_front();
    vecs++;
    if (gnt !== 4'(1 << e)) begin
      errs++;
      $display("FAIL gto_grant: gnt=%b, want %b", gnt, 4'(1 << e));
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      vecs++;
      if (i < 4 && (bus_err !== 4'b0 || gnt !== 4'b0010)) begin
        errs++;
        $display("FAIL gto_wait%0d: err=%b gnt=%b, want 0000 0010",
                 i, bus_err, gnt);
      end else if (i == 4 && (bus_err !== 4'b0010 || gnt !== 4'b0)) begin
        errs++;
        $display("FAIL gto_err: err=%b gnt=%b, want 0010 0000", bus_err, gnt);
      end
    end
    req = 4'b0000;
    tick();
    vecs++;
    if (bus_err !== 4'b0 || bus_oe !== 1'b1) begin
      errs++;
      $display("FAIL gto_after: err=%b oe=%b, want 0000 1", bus_err, bus_oe);
    end
  endtask

  task automatic test_abandon();
    int n, e;
    req = 4'b1000;
    exp_q.push_back(3);
    wait_gnt(n);
    e = exp_q.pop_front();
    vecs++;
    if (gnt !== 4'(1 << e) || owner !== 2'(e)) begin
      errs++;
      $display("FAIL abn_grant: gnt=%b own=%0d, want %b %0d",
               gnt, owner, 4'(1 << e), e);
    end
    repeat (2) tick();
    req = 4'b0000;
    tick();
    vecs++;
    if (gnt !== 4'b0 || busy !== 1'b0 || bus_oe !== 1'b1 || bus_err !== 4'b0) begin
      errs++;
      $display("FAIL abandon: gnt=%b busy=%b oe=%b err=%b, want 0000 0 1 0000",
               gnt, busy, bus_oe, bus_err);
    end
  endtask

  task automatic test_reset_mid();
    int n, e;
    req = 4'b0010;
    exp_q.push_back(1);
    wait_gnt(n);
    e = exp_q.pop_front();
    bus_control = 2'b11;
    req = 4'b0000;
    tick();
    bus_control = 2'b00;
    repeat (2) tick();
    vecs++;
    if (gnt !== 4'(1 << e) || busy !== 1'b1) begin
      errs++;
      $display("FAIL rst_pre: gnt=%b busy=%b, want %b 1", gnt, busy, 4'(1 << e));
    end
    #2;
    n_rst = 1'b0;
    #1;
    vecs++;
    if (gnt !== 4'b0 || bus_oe !== 1'b1 || busy !== 1'b0 || bus_err !== 4'b0) begin
      errs++;
      $display("FAIL rst_async: gnt=%b oe=%b busy=%b err=%b, want 0000 1 0 0000",
               gnt, bus_oe, busy, bus_err);
    end
    tick();
    req = 4'b1111;
    n_rst = 1'b1;
    exp_q.push_back(0);
    wait_gnt(n);
    e = exp_q.pop_front();
    vecs++;
    if (gnt !== 4'(1 << e) || owner !== 2'(e) || n != 1) begin
      errs++;
      $display("FAIL rst_first: gnt=%b own=%0d wait=%0d, want %b %0d 1",
               gnt, owner, n, 4'(1 << e), e);
    end
    bus_control = 2'b01;
    req = 4'b0000;
    tick();
    bus_control = 2'b00;
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_resp();
    test_rsp_timeout(1'b0);
    test_rsp_timeout(1'b1);
    test_gnt_timeout();
    test_abandon();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
